// File: rtl/line_age_tracker.sv
// line_age_tracker: per-set, per-way valid bits and saturating age counters
// feeding victim selection. Hits/fills reset the touched way's age and age the
// other valid ways of the set; invalidates empty a way; a flush sequencer
// clears one set per cycle. Lookups see same-cycle updates (write-before-read).
// Optional macro LINE_AGE_TRACKER_ERR_EN adds a sticky err output for dropped
// illegal or busy-time requests.
module line_age_tracker #(
    parameter int N_WAYS   = 2,
    parameter int N_POW    = 4,
    parameter int N_SETS   = 16,
    parameter int SET_BITS = 4,
    parameter int AGE_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       lookup_valid,
    input  logic [SET_BITS-1:0]        lookup_set,
    output logic                       result_valid,
    output logic [N_WAYS-1:0]          line_empty,
    output logic [N_WAYS-1:0][31:0]    line_age,
    input  logic                       access_valid,
    input  logic                       access_fill,
    input  logic [SET_BITS-1:0]        access_set,
    input  logic [N_POW-1:0]           access_way,
    input  logic                       inv_valid,
    input  logic [SET_BITS-1:0]        inv_set,
    input  logic [N_POW-1:0]           inv_way,
    input  logic                       flush,
    output logic                       busy
`ifdef LINE_AGE_TRACKER_ERR_EN
    ,output logic                      err
`endif
);

    typedef enum logic {S_IDLE, S_FLUSH} state_t;

    state_t                state_q, state_d;
    logic [SET_BITS-1:0]   flush_ptr_q, flush_ptr_d;
    logic [N_WAYS-1:0]     valid_q [N_SETS];
    logic [N_WAYS-1:0]     valid_d [N_SETS];
    logic [AGE_W-1:0]      age_q [N_SETS][N_WAYS];
    logic [AGE_W-1:0]      age_d [N_SETS][N_WAYS];
    logic                  result_valid_q, result_valid_d;
    logic [N_WAYS-1:0]     line_empty_q, line_empty_d;
    logic [N_WAYS-1:0][31:0] line_age_q, line_age_d;

    logic idle;
    logic acc_in_range, acc_tgt_valid, acc_ok;
    logic inv_in_range, inv_ok;
    logic lk_ok;

    function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
        return (a == {AGE_W{1'b1}}) ? a : a + AGE_W'(1);
    endfunction

    function automatic logic [31:0] age_zext(input logic [AGE_W-1:0] a);
        logic [31:0] r;
        r = '0;
        r[AGE_W-1:0] = a;
        return r;
    endfunction

    // Next-state for the array, FSM, flush pointer and registered lookup result.
    always_comb begin
        state_d        = state_q;
        flush_ptr_d    = flush_ptr_q;
        valid_d        = valid_q;
        age_d          = age_q;
        result_valid_d = 1'b0;
        line_empty_d   = line_empty_q;
        line_age_d     = line_age_q;
        acc_tgt_valid  = 1'b0;

        idle         = (state_q == S_IDLE);
        acc_in_range = (32'(access_set) < N_SETS) && (32'(access_way) < N_WAYS);
        inv_in_range = (32'(inv_set) < N_SETS) && (32'(inv_way) < N_WAYS);

        for (int s = 0; s < N_SETS; s++)
            for (int w = 0; w < N_WAYS; w++)
                if (32'(access_set) == s && 32'(access_way) == w)
                    acc_tgt_valid = valid_q[s][w];

        acc_ok = access_valid && idle && acc_in_range && (access_fill || acc_tgt_valid);
        inv_ok = inv_valid && idle && inv_in_range;
        lk_ok  = lookup_valid && idle && (32'(lookup_set) < N_SETS);

        // Access first, then invalidate, so an invalidate wins on its own way.
        for (int s = 0; s < N_SETS; s++) begin
            for (int w = 0; w < N_WAYS; w++) begin
                if (acc_ok && 32'(access_set) == s) begin
                    if (32'(access_way) == w) begin
                        valid_d[s][w] = valid_q[s][w] | access_fill;
                        age_d[s][w]   = '0;
                    end else if (valid_q[s][w]) begin
                        age_d[s][w] = age_sat_inc(age_q[s][w]);
                    end
                end
                if (inv_ok && 32'(inv_set) == s && 32'(inv_way) == w) begin
                    valid_d[s][w] = 1'b0;
                    age_d[s][w]   = '0;
                end
                if (!idle && 32'(flush_ptr_q) == s) begin
                    valid_d[s][w] = 1'b0;
                    age_d[s][w]   = '0;
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (flush) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                if (32'(flush_ptr_q) == N_SETS - 1) begin
                    flush_ptr_d = '0;
                    state_d     = S_IDLE;
                end else begin
                    flush_ptr_d = flush_ptr_q + SET_BITS'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (lk_ok) begin
            result_valid_d = 1'b1;
            for (int s = 0; s < N_SETS; s++)
                if (32'(lookup_set) == s)
                    for (int w = 0; w < N_WAYS; w++) begin
                        line_empty_d[w] = ~valid_d[s][w];
                        line_age_d[w]   = age_zext(age_d[s][w]);
                    end
        end
    end

    // State, array and lookup-result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            flush_ptr_q    <= '0;
            result_valid_q <= 1'b0;
            line_empty_q   <= '1;
            line_age_q     <= '0;
            for (int s = 0; s < N_SETS; s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < N_WAYS; w++) age_q[s][w] <= '0;
            end
        end else begin
            state_q        <= state_d;
            flush_ptr_q    <= flush_ptr_d;
            result_valid_q <= result_valid_d;
            line_empty_q   <= line_empty_d;
            line_age_q     <= line_age_d;
            valid_q        <= valid_d;
            age_q          <= age_d;
        end
    end

    assign busy         = (state_q == S_FLUSH);
    assign result_valid = result_valid_q;
    assign line_empty   = line_empty_q;
    assign line_age     = line_age_q;

`ifdef LINE_AGE_TRACKER_ERR_EN
    logic err_q, err_d;

    // Sticky flag for any request that was dropped.
    always_comb begin
        err_d = err_q;
        if (access_valid && idle && !acc_ok) err_d = 1'b1;
        if (inv_valid && idle && !inv_in_range) err_d = 1'b1;
        if (!idle && (access_valid || inv_valid || lookup_valid)) err_d = 1'b1;
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_line_age_tracker.sv
// Directed self-checking bench for line_age_tracker (default parameters).
module tb_line_age_tracker;

    logic             clk = 1'b0;
    logic             rst;
    logic             lookup_valid;
    logic [3:0]       lookup_set;
    logic             result_valid;
    logic [1:0]       line_empty;
    logic [1:0][31:0] line_age;
    logic             access_valid;
    logic             access_fill;
    logic [3:0]       access_set;
    logic [3:0]       access_way;
    logic             inv_valid;
    logic [3:0]       inv_set;
    logic [3:0]       inv_way;
    logic             flush;
    logic             busy;
`ifdef LINE_AGE_TRACKER_ERR_EN
    logic             err;
`endif

    int checks = 0;
    int errors = 0;

    line_age_tracker dut (
        .clk(clk), .rst(rst),
        .lookup_valid(lookup_valid), .lookup_set(lookup_set),
        .result_valid(result_valid), .line_empty(line_empty), .line_age(line_age),
        .access_valid(access_valid), .access_fill(access_fill),
        .access_set(access_set), .access_way(access_way),
        .inv_valid(inv_valid), .inv_set(inv_set), .inv_way(inv_way),
        .flush(flush), .busy(busy)
`ifdef LINE_AGE_TRACKER_ERR_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic fill, input int s, input int w);
        access_valid = 1'b1;
        access_fill  = fill;
        access_set   = 4'(s);
        access_way   = 4'(w);
        cycle();
        access_valid = 1'b0;
    endtask

    task automatic lookup(input int s);
        lookup_valid = 1'b1;
        lookup_set   = 4'(s);
        cycle();
        lookup_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0) begin $display("FAIL reset_busy got %b want 0", busy); errors++; end
        checks++;
        if (result_valid !== 1'b0) begin $display("FAIL reset_rv got %b want 0", result_valid); errors++; end
        checks++;
        if (line_empty !== 2'b11) begin $display("FAIL reset_empty got %b want 11", line_empty); errors++; end
        checks++;
        if (line_age !== 64'd0) begin $display("FAIL reset_age got %h want 0", line_age); errors++; end
        lookup(3);
        checks++;
        if (result_valid !== 1'b1) begin $display("FAIL lk3_rv got %b want 1", result_valid); errors++; end
        checks++;
        if (line_empty !== 2'b11 || line_age !== 64'd0) begin
            $display("FAIL lk3_data got empty=%b age=%h want empty=11 age=0", line_empty, line_age); errors++;
        end
        cycle();
        checks++;
        if (result_valid !== 1'b0) begin $display("FAIL rv_drop got %b want 0", result_valid); errors++; end
    endtask

    task automatic test_access();
        access(1'b1, 5, 0);
        access(1'b1, 5, 1);
        access(1'b0, 5, 0);
        lookup(5);
        checks++;
        if (line_empty !== 2'b00 || line_age[0] !== 32'd0 || line_age[1] !== 32'd1) begin
            $display("FAIL set5_basic got empty=%b age0=%0d age1=%0d want 00/0/1", line_empty, line_age[0], line_age[1]); errors++;
        end
        lookup(4);
        checks++;
        if (line_empty !== 2'b11 || line_age !== 64'd0) begin
            $display("FAIL set4_untouched got empty=%b age=%h want 11/0", line_empty, line_age); errors++;
        end
        // hit to an empty way is dropped
        access(1'b0, 6, 0);
        lookup(6);
        checks++;
        if (line_empty !== 2'b11) begin $display("FAIL hit_empty got empty=%b want 11", line_empty); errors++; end
        // out-of-range way is dropped: set 5 must not age
        access(1'b1, 5, 2);
        lookup(5);
        checks++;
        if (line_empty !== 2'b00 || line_age[0] !== 32'd0 || line_age[1] !== 32'd1) begin
            $display("FAIL bad_way got empty=%b age0=%0d age1=%0d want 00/0/1", line_empty, line_age[0], line_age[1]); errors++;
        end
        access(1'b0, 5, 1);
        lookup(5);
        checks++;
        if (line_age[0] !== 32'd1 || line_age[1] !== 32'd0) begin
            $display("FAIL set5_hit1 got age0=%0d age1=%0d want 1/0", line_age[0], line_age[1]); errors++;
        end
    endtask

    task automatic test_saturation();
        access(1'b1, 2, 0);
        access(1'b1, 2, 1);
        for (int i = 0; i < 253; i++) access(1'b0, 2, 1);
        lookup(2);
        checks++;
        if (line_age[0] !== 32'd254 || line_age[1] !== 32'd0) begin
            $display("FAIL sat_pre got age0=%0d age1=%0d want 254/0", line_age[0], line_age[1]); errors++;
        end
        for (int i = 0; i < 47; i++) access(1'b0, 2, 1);
        lookup(2);
        checks++;
        if (line_age[0] !== 32'd255 || line_age[1] !== 32'd0 || line_empty !== 2'b00) begin
            $display("FAIL sat_max got age0=%0d age1=%0d empty=%b want 255/0/00", line_age[0], line_age[1], line_empty); errors++;
        end
    endtask

    task automatic test_same_cycle();
        access(1'b1, 1, 0);
        access(1'b1, 1, 1);
        access_valid = 1'b1; access_fill = 1'b0; access_set = 4'd1; access_way = 4'd0;
        inv_valid = 1'b1; inv_set = 4'd1; inv_way = 4'd0;
        cycle();
        access_valid = 1'b0; inv_valid = 1'b0;
        lookup(1);
        checks++;
        if (line_empty !== 2'b01 || line_age[0] !== 32'd0 || line_age[1] !== 32'd1) begin
            $display("FAIL same_set got empty=%b age0=%0d age1=%0d want 01/0/1", line_empty, line_age[0], line_age[1]); errors++;
        end
        // different sets in one cycle: fill set 7 way 0, invalidate set 5 way 1
        access_valid = 1'b1; access_fill = 1'b1; access_set = 4'd7; access_way = 4'd0;
        inv_valid = 1'b1; inv_set = 4'd5; inv_way = 4'd1;
        cycle();
        access_valid = 1'b0; inv_valid = 1'b0;
        lookup(5);
        checks++;
        if (line_empty !== 2'b10 || line_age[0] !== 32'd1 || line_age[1] !== 32'd0) begin
            $display("FAIL diff_set5 got empty=%b age0=%0d age1=%0d want 10/1/0", line_empty, line_age[0], line_age[1]); errors++;
        end
        lookup(7);
        checks++;
        if (line_empty !== 2'b10 || line_age !== 64'd0) begin
            $display("FAIL diff_set7 got empty=%b age=%h want 10/0", line_empty, line_age); errors++;
        end
    endtask

    task automatic test_bypass();
        access_valid = 1'b1; access_fill = 1'b1; access_set = 4'd7; access_way = 4'd1;
        lookup_valid = 1'b1; lookup_set = 4'd7;
        cycle();
        access_valid = 1'b0; lookup_valid = 1'b0;
        checks++;
        if (result_valid !== 1'b1 || line_empty !== 2'b00 || line_age[0] !== 32'd1 || line_age[1] !== 32'd0) begin
            $display("FAIL bypass got rv=%b empty=%b age0=%0d age1=%0d want 1/00/1/0", result_valid, line_empty, line_age[0], line_age[1]); errors++;
        end
    endtask

    task automatic test_flush();
        int cnt;
        int bad_rv;
        access(1'b1, 9, 0);
        flush = 1'b1;
        lookup_valid = 1'b1; lookup_set = 4'd9;
        cycle();
        flush = 1'b0;
        checks++;
        if (busy !== 1'b1 || result_valid !== 1'b1 || line_empty !== 2'b10) begin
            $display("FAIL flush_start got busy=%b rv=%b empty=%b want 1/1/10", busy, result_valid, line_empty); errors++;
        end
        lookup_valid = 1'b1; lookup_set = 4'd11;
        access_valid = 1'b1; access_fill = 1'b1; access_set = 4'd11; access_way = 4'd0;
        inv_valid = 1'b1; inv_set = 4'd9; inv_way = 4'd0;
        cnt = 1;
        bad_rv = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy !== 1'b1) break;
            cycle();
            if (busy === 1'b1) cnt++;
            if (result_valid !== 1'b0) bad_rv++;
        end
        lookup_valid = 1'b0; access_valid = 1'b0; inv_valid = 1'b0;
        checks++;
        if (cnt !== 16) begin $display("FAIL flush_len got %0d cycles want 16", cnt); errors++; end
        checks++;
        if (bad_rv !== 0) begin $display("FAIL flush_rv got %0d valid results want 0", bad_rv); errors++; end
        for (int s = 0; s < 16; s++) begin
            lookup(s);
            checks++;
            if (result_valid !== 1'b1 || line_empty !== 2'b11 || line_age !== 64'd0) begin
                $display("FAIL post_flush_set%0d got rv=%b empty=%b age=%h want 1/11/0", s, result_valid, line_empty, line_age); errors++;
            end
        end
        // reset aborts a flush in progress
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0) begin $display("FAIL rst_abort_busy got %b want 0", busy); errors++; end
        access(1'b1, 0, 0);
        lookup(0);
        checks++;
        if (line_empty !== 2'b10) begin $display("FAIL rst_abort_idle got empty=%b want 10", line_empty); errors++; end
    endtask

`ifdef LINE_AGE_TRACKER_ERR_EN
    task automatic test_err();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++;
        if (err !== 1'b0) begin $display("FAIL err_reset got %b want 0", err); errors++; end
        access(1'b0, 0, 1);
        checks++;
        if (err !== 1'b1) begin $display("FAIL err_set got %b want 1", err); errors++; end
        lookup(0);
        checks++;
        if (line_empty !== 2'b11 || err !== 1'b1) begin
            $display("FAIL err_sticky got empty=%b err=%b want 11/1", line_empty, err); errors++;
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++;
        if (err !== 1'b0) begin $display("FAIL err_clear got %b want 0", err); errors++; end
    endtask
`endif

    initial begin
        rst = 1'b1;
        lookup_valid = 1'b0; lookup_set = '0;
        access_valid = 1'b0; access_fill = 1'b0; access_set = '0; access_way = '0;
        inv_valid = 1'b0; inv_set = '0; inv_way = '0;
        flush = 1'b0;
        test_reset();
        test_access();
        test_saturation();
        test_same_cycle();
        test_bypass();
        test_flush();
`ifdef LINE_AGE_TRACKER_ERR_EN
        test_err();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
